// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register map, CTRL fields and FSM encoding for timer_dev
//
// Purpose: one place for the constants that the timer and the bridge address
// decode both depend on.
//   ADDR_*        word index = bus addr[3:2]
//   CTRL_*        bit positions inside the CTRL register
//   MODE_*        CTRL.MODE values (2 and 3 behave as one-shot)
//   state_t       countdown FSM encoding, IDLE = 0
package timer_dev_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - bridge-to-timer register bus and interrupt line
//
// Purpose: bundles the word-addressed register bus seen by the timer.
//   addr   [1:0]  word select (bus addr[3:2])
//   we            write strobe, already qualified with the timer select
//   wdata  [31:0] write data
//   rdata  [31:0] combinational read data for addr
//   irq           interrupt request toward CP0 HWInt
// Modports: master = bridge side, slave = timer side.
interface timer_dev_if;

  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);

endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot and auto-reload modes
//
// Purpose: CPU-visible countdown timer. CTRL enables counting and selects the
// mode, PRESET is the reload value, COUNT is the read-only live counter. When
// the count expires irq_pend is set; irq = irq_pend & CTRL.IM.
// Ports:
//   clk    in   system clock, all state on posedge
//   reset  in   synchronous active-high reset
//   bus    slave modport of timer_dev_if (addr/we/wdata/rdata/irq)
// Parameters:
//   CNT_W       width of PRESET and COUNT (1..32), reads zero-extended
//   PRESET_RST  reset value of PRESET
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_pend;
  state_t           state;

  state_t           state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             set_pend;
  logic             clr_pend;
  logic             clr_en;

  logic             wr_ctrl;
  logic             wr_preset;

  // COUNT is not writable, so addr 2 and 3 writes decode to nothing.
  assign wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
  assign wr_preset = bus.we && (bus.addr == ADDR_PRESET);

  // Next-state logic works only on registered CTRL/PRESET, so a bus write
  // becomes visible to the FSM one cycle after its edge.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    clr_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else begin
          count_nxt = preset;
          state_nxt = S_CNT;
        end
      end
      S_CNT: begin
        if (!en) begin
          state_nxt = S_IDLE;
        end else if (count > CNT_W'(1)) begin
          count_nxt = count - CNT_W'(1);
        end else begin
          // COUNT of 0 (PRESET=0) expires like 1 instead of wrapping.
          count_nxt = '0;
          set_pend  = 1'b1;
          state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (mode == MODE_RELOAD) begin
          clr_pend  = 1'b1;
          state_nxt = S_LOAD;
        end else begin
          clr_en    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      preset   <= PRESET_RST;
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      im       <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;

      if (wr_preset) preset <= bus.wdata[CNT_W-1:0];

      // A CTRL write overrides the FSM's own EN clear in the same cycle.
      if (wr_ctrl) begin
        en   <= bus.wdata[CTRL_EN];
        mode <= bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
        im   <= bus.wdata[CTRL_IM];
      end else if (clr_en) begin
        en <= 1'b0;
      end

      // A CTRL write acknowledges the interrupt and beats any FSM set/clear.
      if (wr_ctrl)       irq_pend <= 1'b0;
      else if (set_pend) irq_pend <= 1'b1;
      else if (clr_pend) irq_pend <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      ADDR_CTRL:   bus.rdata = {28'b0, im, mode, en};
      ADDR_PRESET: bus.rdata = 32'(preset);
      ADDR_COUNT:  bus.rdata = 32'(count);
      default:     bus.rdata = '0;
    endcase
  end

  assign bus.irq = irq_pend & im;

endmodule
